sweep_controller: RTL and testbench

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

---
 rtl/sweep_controller.sv | 178 +++++++++++++++++
 tb/tb_sweep_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_controller.sv
// Sweeps an 8-bit stimulus through a circuit under test, stores each response
// in a result RAM, and streams the RAM back out over a UART on command.
module sweep_controller #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TX_TIMEOUT    = 65535
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iRxDone,
    input  logic [7:0] iRxData,
    input  logic       iTxDone,
    output logic       oTxSend,
    output logic [7:0] oTxData,
    output logic [7:0] oGenIn,
    input  logic [7:0] iGenOut,
    output logic [7:0] oMemAddr,
    output logic [7:0] oMemData,
    output logic       oMemWrite,
    input  logic [7:0] iMemQ,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError,
    output logic       oSerialReset
);

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        WRITE,
        RD_ADDR,
        RD_WAIT,
        SEND,
        WAIT_TX,
        FINISH,
        ABORT
    } state_t;

    localparam logic [7:0]  CMD_SWEEP = 8'h53;
    localparam logic [7:0]  CMD_TX    = 8'h54;
    localparam logic [7:0]  CMD_GO    = 8'h47;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TX_LAST     = 16'(TX_TIMEOUT - 1);

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [7:0]  tx_addr;
    logic [15:0] tx_cnt;
    logic        then_tx;

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state        <= IDLE;
            settle_cnt   <= 8'd0;
            tx_addr      <= 8'd0;
            tx_cnt       <= 16'd0;
            then_tx      <= 1'b0;
            oGenIn       <= 8'd0;
            oMemAddr     <= 8'd0;
            oMemData     <= 8'd0;
            oMemWrite    <= 1'b0;
            oTxData      <= 8'd0;
            oTxSend      <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oError       <= 1'b0;
            oSerialReset <= 1'b0;
        end else begin
            // Pulse outputs drop unless the transition below re-asserts them.
            oMemWrite    <= 1'b0;
            oTxSend      <= 1'b0;
            oDone        <= 1'b0;
            oSerialReset <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (iRxDone) begin
                        case (iRxData)
                            CMD_SWEEP, CMD_GO: begin
                                state      <= SETTLE;
                                then_tx    <= (iRxData == CMD_GO);
                                oGenIn     <= 8'd0;
                                settle_cnt <= 8'd0;
                                tx_cnt     <= 16'd0;
                                oBusy      <= 1'b1;
                                oError     <= 1'b0;
                            end
                            CMD_TX: begin
                                state    <= RD_ADDR;
                                then_tx  <= 1'b1;
                                tx_addr  <= 8'd0;
                                oMemAddr <= 8'd0;
                                tx_cnt   <= 16'd0;
                                oBusy    <= 1'b1;
                                oError   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state     <= WRITE;
                        oMemWrite <= 1'b1;
                        oMemAddr  <= oGenIn;
                        oMemData  <= iGenOut;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end

                WRITE: begin
                    if (oGenIn != 8'hFF) begin
                        oGenIn     <= oGenIn + 8'd1;
                        settle_cnt <= 8'd0;
                        state      <= SETTLE;
                    end else if (then_tx) begin
                        state    <= RD_ADDR;
                        tx_addr  <= 8'd0;
                        oMemAddr <= 8'd0;
                    end else begin
                        state <= FINISH;
                        oDone <= 1'b1;
                    end
                end

                RD_ADDR: state <= RD_WAIT;

                RD_WAIT: begin
                    state   <= SEND;
                    oTxData <= iMemQ;
                    oTxSend <= 1'b1;
                end

                // A done pulse overlapping SEND belongs to no byte of ours.
                SEND: begin
                    state  <= WAIT_TX;
                    tx_cnt <= 16'd0;
                end

                WAIT_TX: begin
                    if (iTxDone) begin
                        if (tx_addr != 8'hFF) begin
                            tx_addr  <= tx_addr + 8'd1;
                            oMemAddr <= tx_addr + 8'd1;
                            state    <= RD_ADDR;
                        end else begin
                            state <= FINISH;
                            oDone <= 1'b1;
                        end
                    end else if (tx_cnt == TX_LAST) begin
                        state        <= ABORT;
                        oSerialReset <= 1'b1;
                        oError       <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end

                ABORT: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_controller.sv
// Randomised scoreboard bench for sweep_controller with RAM, circuit and
// UART models around it.
module tb_sweep_controller;

    localparam int SC = 4;
    localparam int TO = 100;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [7:0] gen_in;
    logic [7:0] gen_out;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_write;
    logic [7:0] mem_q;
    logic       busy;
    logic       done;
    logic       error;
    logic       ser_rst;

    always #5 CLOCK_50 = ~CLOCK_50;

    sweep_controller #(.SETTLE_CYCLES(SC), .TX_TIMEOUT(TO)) dut (
        .iClock(CLOCK_50), .iReset(rst_n),
        .iRxDone(rx_done), .iRxData(rx_data),
        .iTxDone(tx_done), .oTxSend(tx_send), .oTxData(tx_data),
        .oGenIn(gen_in), .iGenOut(gen_out),
        .oMemAddr(mem_addr), .oMemData(mem_data),
        .oMemWrite(mem_write), .iMemQ(mem_q),
        .oBusy(busy), .oDone(done), .oError(error),
        .oSerialReset(ser_rst)
    );

    // Circuit under evaluation.
    int         mode;
    logic [7:0] key;

    function automatic logic [7:0] circ(int m, logic [7:0] x, logic [7:0] k);
        case (m)
            0:       return ~x;
            1:       return x + 8'd1;
            default: return x ^ k;
        endcase
    endfunction

    assign gen_out = circ(mode, gen_in, key);

    // Result RAM, one-cycle read latency.
    logic [7:0] ram [256];
    logic       preload_req;

    always @(posedge CLOCK_50) begin
        if (preload_req) begin
            for (int a = 0; a < 256; a++) ram[a] <= 8'(a) ^ 8'h5A;
        end else if (mem_write) begin
            ram[mem_addr] <= mem_data;
        end
        mem_q <= ram[mem_addr];
    end

    // UART model.
    int lat_fixed;
    bit spur;
    bit withhold;

    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (tx_send && !withhold) begin
                int l;
                l = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 20));
                tx_done = spur;
                repeat (l) begin
                    @(negedge CLOCK_50);
                    tx_done = 1'b0;
                end
                tx_done = 1'b1;
                @(negedge CLOCK_50);
                tx_done = 1'b0;
            end
        end
    end

    // Scoreboard.
    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        bit abort;
        int cyc;
    } end_t;

    wr_t        wq[$];
    logic [7:0] tq[$];
    end_t       eq[$];
    logic [7:0] mdl [256];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int end_cnt = 0;
    int last_send = 0;
    int busy_low = 0;

    function automatic void chk(bit ok, string name, string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, msg);
        end
    endfunction

    initial begin
        bit   after_end;
        bit   prev_abort;
        wr_t  w;
        end_t e;
        int   ec;
        after_end = 1'b0;
        prev_abort = 1'b0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            if (mem_write) begin
                if (wq.size() == 0) begin
                    chk(1'b0, "write_unexpected",
                        $sformatf("got a=%02h d=%02h, required none", mem_addr, mem_data));
                end else begin
                    w = wq.pop_front();
                    chk(mem_addr == w.addr && mem_data == w.data && cyc == w.cyc, "write",
                        $sformatf("got a=%02h d=%02h cyc=%0d, required a=%02h d=%02h cyc=%0d",
                                  mem_addr, mem_data, cyc, w.addr, w.data, w.cyc));
                end
            end
            if (tx_send) begin
                last_send = cyc;
                if (tq.size() == 0) begin
                    chk(1'b0, "tx_unexpected",
                        $sformatf("got byte %02h, required none", tx_data));
                end else begin
                    logic [7:0] t;
                    t = tq.pop_front();
                    chk(tx_data == t, "tx_byte",
                        $sformatf("got %02h, required %02h", tx_data, t));
                end
            end
            if (done || ser_rst) begin
                if (eq.size() == 0) begin
                    chk(1'b0, "end_unexpected",
                        $sformatf("got done=%0b serial_reset=%0b, required none", done, ser_rst));
                end else begin
                    e = eq.pop_front();
                    ec = e.abort ? last_send + TO + 1 : e.cyc;
                    chk(done == !e.abort && ser_rst == e.abort && error == e.abort
                        && (ec < 0 || cyc == ec) && wq.size() == 0 && tq.size() == 0
                        && busy && busy_low == 0, "end",
                        $sformatf("got done=%0b srst=%0b err=%0b busy=%0b cyc=%0d left=%0d/%0d busy_low=%0d, required done=%0b srst=%0b err=%0b busy=1 cyc=%0d left=0/0 busy_low=0",
                                  done, ser_rst, error, busy, cyc, wq.size(), tq.size(), busy_low,
                                  !e.abort, e.abort, e.abort, ec));
                    prev_abort = e.abort;
                end
                after_end = 1'b1;
                end_cnt++;
            end else if (after_end) begin
                after_end = 1'b0;
                chk(!busy && !done && !ser_rst && error == prev_abort, "idle_after",
                    $sformatf("got busy=%0b done=%0b srst=%0b err=%0b, required 0 0 0 %0b",
                              busy, done, ser_rst, error, prev_abort));
            end
            if (eq.size() == 0) busy_low = 0;
            else if (!busy) busy_low++;
        end
    end

    function automatic logic [7:0] noise_byte();
        case ($urandom_range(0, 4))
            0:       return 8'h53;
            1:       return 8'h54;
            2:       return 8'h47;
            3:       return 8'h41;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic flush_and_reset();
        @(negedge CLOCK_50);
        rx_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        wq.delete();
        tq.delete();
        eq.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_cmd(logic [7:0] c, bit noise);
        int c0;
        int start_end;
        bit sweep;
        bit tx;
        int n;
        sweep = (c == 8'h53) || (c == 8'h47);
        tx = (c == 8'h54) || (c == 8'h47);
        start_end = end_cnt;
        @(negedge CLOCK_50);
        // The command is sampled at the next edge; SETTLE starts there.
        c0 = cyc + 1;
        if (sweep) begin
            for (int a = 0; a < 256; a++) begin
                mdl[a] = circ(mode, 8'(a), key);
                wq.push_back('{c0 + SC + (SC + 1) * a, 8'(a), mdl[a]});
            end
        end
        if (tx) begin
            for (int a = 0; a < (withhold ? 1 : 256); a++) tq.push_back(mdl[a]);
        end
        eq.push_back('{withhold, (sweep && !tx) ? c0 + 256 * (SC + 1) : -1});
        rx_done = 1'b1;
        rx_data = c;
        @(negedge CLOCK_50);
        rx_done = 1'b0;
        for (n = 0; n < 20000 && end_cnt == start_end; n++) begin
            @(negedge CLOCK_50);
            if (rx_done) begin
                rx_done = 1'b0;
            end else if (noise && (wq.size() > 2 || tq.size() > 2)
                         && $urandom_range(0, 39) == 0) begin
                rx_done = 1'b1;
                rx_data = noise_byte();
            end
        end
        rx_done = 1'b0;
        if (end_cnt == start_end) begin
            chk(1'b0, "timeout", $sformatf("got no end for cmd %02h, required one", c));
            flush_and_reset();
        end
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        rst_n = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        mode = 0;
        key = 8'h00;
        withhold = 1'b0;
        spur = 1'b0;
        lat_fixed = 0;
        preload_req = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk({gen_in, mem_addr, mem_data, mem_write, tx_data, tx_send,
             busy, done, error, ser_rst} == '0, "reset_values",
            $sformatf("got gen=%02h addr=%02h data=%02h we=%0b txd=%02h send=%0b busy=%0b done=%0b err=%0b srst=%0b, required all 0",
                      gen_in, mem_addr, mem_data, mem_write, tx_data, tx_send,
                      busy, done, error, ser_rst));
        rst_n = 1'b1;
        for (int a = 0; a < 256; a++) mdl[a] = 8'h00;
        @(negedge CLOCK_50);
        preload_req = 1'b1;
        @(negedge CLOCK_50);
        preload_req = 1'b0;
        for (int a = 0; a < 256; a++) mdl[a] = 8'(a) ^ 8'h5A;

        // Non-command bytes in IDLE.
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = (i == 0) ? 8'h41 : 8'h00;
            @(negedge CLOCK_50);
            rx_done = 1'b1;
            rx_data = b;
            @(negedge CLOCK_50);
            rx_done = 1'b0;
            repeat (6) @(negedge CLOCK_50);
            chk(!busy, "ignore_idle",
                $sformatf("got busy=%0b after byte %02h, required 0", busy, b));
        end

        // Sweep only, response ~x, stray commands mid-sweep.
        mode = 0;
        run_cmd(8'h53, 1'b1);

        // Transmit preset RAM, fixed 10-cycle UART, stray done during SEND.
        @(negedge CLOCK_50);
        preload_req = 1'b1;
        @(negedge CLOCK_50);
        preload_req = 1'b0;
        for (int a = 0; a < 256; a++) mdl[a] = 8'(a) ^ 8'h5A;
        lat_fixed = 10;
        spur = 1'b1;
        run_cmd(8'h54, 1'b0);

        // Sweep then transmit, response x+1.
        mode = 1;
        lat_fixed = 0;
        spur = 1'b0;
        run_cmd(8'h47, 1'b1);

        // UART never answers.
        withhold = 1'b1;
        run_cmd(8'h54, 1'b0);
        withhold = 1'b0;
        run_cmd(8'h54, 1'b0);

        for (int i = 0; i < 3; i++) begin
            logic [7:0] c;
            mode = 2;
            key = 8'($urandom);
            spur = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       c = 8'h53;
                1:       c = 8'h54;
                default: c = 8'h47;
            endcase
            run_cmd(c, 1'b1);
        end

        // Reset mid-sweep at value 0x80, coincident with a command byte.
        begin
            int n;
            mode = 0;
            @(negedge CLOCK_50);
            for (int a = 0; a < 256; a++)
                wq.push_back('{cyc + 1 + SC + (SC + 1) * a, 8'(a), circ(mode, 8'(a), key)});
            eq.push_back('{1'b0, cyc + 1 + 256 * (SC + 1)});
            rx_done = 1'b1;
            rx_data = 8'h53;
            @(negedge CLOCK_50);
            rx_done = 1'b0;
            for (n = 0; n < 2000 && gen_in != 8'h80; n++) @(negedge CLOCK_50);
            chk(gen_in == 8'h80, "reach_80",
                $sformatf("got gen=%02h, required 80", gen_in));
            rst_n = 1'b0;
            rx_done = 1'b1;
            rx_data = 8'h54;
            @(negedge CLOCK_50);
            chk({gen_in, mem_addr, mem_data, mem_write, tx_data, tx_send,
                 busy, done, error, ser_rst} == '0, "reset_mid",
                $sformatf("got gen=%02h addr=%02h data=%02h we=%0b txd=%02h send=%0b busy=%0b done=%0b err=%0b srst=%0b, required all 0",
                          gen_in, mem_addr, mem_data, mem_write, tx_data, tx_send,
                          busy, done, error, ser_rst));
            chk(wq.size() == 128, "writes_before_reset",
                $sformatf("got %0d pending, required 128", wq.size()));
            rx_done = 1'b0;
            rst_n = 1'b1;
            wq.delete();
            eq.delete();
            repeat (30) @(negedge CLOCK_50);
            chk(!busy && gen_in == 8'h00, "idle_after_reset",
                $sformatf("got busy=%0b gen=%02h, required 0 00", busy, gen_in));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
